// File: rtl/psum_acc_if.sv
`default_nettype none
// ============================================================================
//  Module      : psum_acc_if
//  Description : Partial-sum beat stream in, per-window result stream out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface psum_acc_if #(
    parameter int DN   = 7,
    parameter int IW   = 18,
    parameter int DW   = 26,
    parameter int CW   = 25,
    parameter int CNTW = 10
);
    // Beat stream from the PE array
    logic [DN*IW-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic [CW-1:0]    in_ctrl;
    logic [DN*DW-1:0] bias;
    logic             flush;

    // Window results towards the scale stage
    logic [DN*DW-1:0] s_data;
    logic             s_valid;
    logic [CW-1:0]    s_ctrl;
    logic [DN-1:0]    s_sat;
    logic [CNTW-1:0]  s_beats;
    logic             s_err;

    // Producer side: drives beats, observes results
    modport master (
        output in_data, in_valid, in_last, in_ctrl, bias, flush,
        input  s_data, s_valid, s_ctrl, s_sat, s_beats, s_err
    );

    // Accumulator side: consumes beats, produces results
    modport slave (
        input  in_data, in_valid, in_last, in_ctrl, bias, flush,
        output s_data, s_valid, s_ctrl, s_sat, s_beats, s_err
    );
endinterface
`default_nettype wire

// File: rtl/psum_acc.sv
`default_nettype none
// ============================================================================
//  Module      : psum_acc
//  Description : Per-channel saturating partial-sum accumulator with bias.
//                Sums DN signed lanes over a window closed by in_last (or by
//                the MAXB beat limit) and emits one result vector per window.
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_acc #(
    parameter int DN   = 7,
    parameter int IW   = 18,
    parameter int DW   = 26,
    parameter int CW   = 25,
    parameter int CNTW = 10
) (
    input  wire        clk,
    input  wire        rst,
    psum_acc_if.slave  bus
);
    localparam logic [0:0]      c_S_IDLE = 1'b0;
    localparam logic [0:0]      c_S_ACC  = 1'b1;
    localparam logic [CNTW-1:0] c_MAXB   = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] c_ONE    = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]   c_MAX    = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]   c_MIN    = {1'b1, {(DW-1){1'b0}}};

    logic [0:0]       r_state;
    logic [DN*DW-1:0] r_acc;
    logic [DN-1:0]    r_sat;
    logic [CNTW-1:0]  r_cnt;
    logic [CW-1:0]    r_ctrl;

    logic [DN*DW-1:0] r_s_data;
    logic             r_s_valid;
    logic [CW-1:0]    r_s_ctrl;
    logic [DN-1:0]    r_s_sat;
    logic [CNTW-1:0]  r_s_beats;
    logic             r_s_err;

    logic             w_first;
    logic             w_beat;
    logic             w_close;
    logic [CNTW-1:0]  w_cnt_next;
    logic [DN*DW-1:0] w_acc_next;
    logic [DN-1:0]    w_sat_hit;
    logic [DN-1:0]    w_sat_next;
    logic [CW-1:0]    w_ctrl_next;

    // Flush takes priority over a coincident beat, so the beat is dropped
    assign w_first     = (r_state == c_S_IDLE);
    assign w_beat      = bus.in_valid & ~bus.flush;
    assign w_cnt_next  = w_first ? c_ONE : (r_cnt + c_ONE);
    assign w_close     = w_beat & (bus.in_last | (w_cnt_next == c_MAXB));
    assign w_sat_next  = w_first ? w_sat_hit : (r_sat | w_sat_hit);
    assign w_ctrl_next = w_first ? bus.in_ctrl : r_ctrl;

    // Per-lane saturating add: first beat seeds from bias, later beats from acc
    for (genvar i = 0; i < DN; i++) begin : g_lane
        logic [DW-1:0] w_base;
        logic [IW-1:0] w_in;
        logic [DW:0]   w_sum;
        logic          w_ovf;

        assign w_base = w_first ? bus.bias[i*DW +: DW] : r_acc[i*DW +: DW];
        assign w_in   = bus.in_data[i*IW +: IW];
        assign w_sum  = {w_base[DW-1], w_base} + {{(DW+1-IW){w_in[IW-1]}}, w_in};
        assign w_ovf  = w_sum[DW] ^ w_sum[DW-1];
        assign w_acc_next[i*DW +: DW] = w_ovf ? (w_sum[DW] ? c_MIN : c_MAX)
                                              : w_sum[DW-1:0];
        assign w_sat_hit[i] = w_ovf;
    end

    // Window FSM, accumulator state and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_acc     <= '0;
            r_sat     <= '0;
            r_cnt     <= '0;
            r_ctrl    <= '0;
            r_s_data  <= '0;
            r_s_valid <= 1'b0;
            r_s_ctrl  <= '0;
            r_s_sat   <= '0;
            r_s_beats <= '0;
            r_s_err   <= 1'b0;
        end else begin
            r_s_valid <= 1'b0;
            if (bus.flush) begin
                // Partial window is abandoned; IDLE re-seeds acc from bias
                r_state <= c_S_IDLE;
            end else if (bus.in_valid) begin
                r_acc  <= w_acc_next;
                r_sat  <= w_sat_next;
                r_cnt  <= w_cnt_next;
                r_ctrl <= w_ctrl_next;
                if (w_close) begin
                    r_state   <= c_S_IDLE;
                    r_s_valid <= 1'b1;
                    r_s_data  <= w_acc_next;
                    r_s_ctrl  <= w_ctrl_next;
                    r_s_sat   <= w_sat_next;
                    r_s_beats <= w_cnt_next;
                    r_s_err   <= ~bus.in_last;
                end else begin
                    r_state <= c_S_ACC;
                end
            end
        end
    end

    assign bus.s_data  = r_s_data;
    assign bus.s_valid = r_s_valid;
    assign bus.s_ctrl  = r_s_ctrl;
    assign bus.s_sat   = r_s_sat;
    assign bus.s_beats = r_s_beats;
    assign bus.s_err   = r_s_err;

    // w_beat documents the accept condition; close logic folds it in directly
    logic w_unused;
    assign w_unused = w_beat;
endmodule
`default_nettype wire

// File: tb/tb_psum_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_acc
//  Description : Scoreboard bench for psum_acc (beat limit reduced to 7).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_acc;
    localparam int DN   = 7;
    localparam int IW   = 18;
    localparam int DW   = 26;
    localparam int CW   = 25;
    localparam int CNTW = 3;
    localparam int TW   = DN*DW;

    typedef struct {
        logic [TW-1:0]   d;
        logic [CW-1:0]   c;
        logic [DN-1:0]   s;
        logic [CNTW-1:0] b;
        logic            e;
        int              cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t m_e;

    psum_acc_if #(.DN(DN), .IW(IW), .DW(DW), .CW(CW), .CNTW(CNTW)) bus ();

    psum_acc #(.DN(DN), .IW(IW), .DW(DW), .CW(CW), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DN*IW-1:0] ivec(input int v0, input int v1, input int vr);
        logic [DN*IW-1:0] r;
        for (int i = 0; i < DN; i++)
            r[i*IW +: IW] = IW'((i == 0) ? v0 : (i == 1) ? v1 : vr);
        return r;
    endfunction

    function automatic logic [TW-1:0] dvec(input int v0, input int v1, input int vr);
        logic [TW-1:0] r;
        for (int i = 0; i < DN; i++)
            r[i*DW +: DW] = DW'((i == 0) ? v0 : (i == 1) ? v1 : vr);
        return r;
    endfunction

    task automatic drive(input logic v, input logic l, input logic fl,
                         input logic [DN*IW-1:0] d, input logic [CW-1:0] c,
                         input logic [TW-1:0] b);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_last  = l;
        bus.flush    = fl;
        bus.in_data  = d;
        bus.in_ctrl  = c;
        bus.bias     = b;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Called right after the closing beat is driven: result seen one clock later
    task automatic expect_emit(input logic [TW-1:0] d, input logic [CW-1:0] c,
                               input logic [DN-1:0] s, input int b, input logic e);
        exp_t x;
        x.d = d; x.c = c; x.s = s; x.b = CNTW'(b); x.e = e; x.cyc = cyc + 1;
        q.push_back(x);
    endtask

    // Monitor: every presented result must match the oldest expectation
    always @(negedge clk) begin
        if (bus.s_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_emit: got s_valid=1 at cycle %0d expected none", cyc);
            end else begin
                m_e = q.pop_front();
                chk("emit_cycle", TW'(cyc), TW'(m_e.cyc));
                chk("s_data", bus.s_data, m_e.d);
                chk("s_ctrl", TW'(bus.s_ctrl), TW'(m_e.c));
                chk("s_sat", TW'(bus.s_sat), TW'(m_e.s));
                chk("s_beats", TW'(bus.s_beats), TW'(m_e.b));
                chk("s_err", TW'(bus.s_err), TW'(m_e.e));
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_s_data"}, bus.s_data, '0);
        chk({tag, "_s_valid"}, TW'(bus.s_valid), '0);
        chk({tag, "_s_ctrl"}, TW'(bus.s_ctrl), '0);
        chk({tag, "_s_sat"}, TW'(bus.s_sat), '0);
        chk({tag, "_s_beats"}, TW'(bus.s_beats), '0);
        chk({tag, "_s_err"}, TW'(bus.s_err), '0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.flush = 1'b0;
        bus.in_data = '0; bus.in_ctrl = '0; bus.bias = '0;
        idle(3);
        chk_zero("reset");
        rst = 1'b0;
        idle(2);

        // T1: 4-beat window, lane0 +10, lane1 -10, bias 100; stray in_last ignored
        drive(1, 0, 0, ivec(10, -10, 0), 25'h0000123, dvec(100, 100, 100));
        drive(1, 0, 0, ivec(10, -10, 0), 25'h1FFFFFF, dvec(0, 0, 0));
        drive(0, 1, 0, ivec(99, 99, 99), 25'h1FFFFFF, dvec(0, 0, 0));
        drive(1, 0, 0, ivec(10, -10, 0), 25'h1FFFFFF, dvec(0, 0, 0));
        drive(1, 1, 0, ivec(10, -10, 0), 25'h1FFFFFF, dvec(0, 0, 0));
        expect_emit(dvec(140, 60, 100), 25'h0000123, 7'h00, 4, 1'b0);
        idle(2);

        // T2a: positive clamp on lane0, negative clamp then recovery on lane1
        drive(1, 0, 0, ivec(1, -1, 0), 25'h2, dvec(33554431, -33554432, 0));
        drive(1, 1, 0, ivec(5, 5, 0), 25'h0, dvec(0, 0, 0));
        expect_emit(dvec(33554431, -33554427, 0), 25'h2, 7'h03, 2, 1'b0);
        idle(1);
        // T2b: negative clamp on all lanes, single beat
        drive(1, 1, 0, ivec(-1, -1, -1), 25'h3, dvec(-33554432, -33554432, -33554432));
        expect_emit(dvec(-33554432, -33554432, -33554432), 25'h3, 7'h7F, 1, 1'b0);
        idle(1);

        // T3: back-to-back windows 1, 3, 1 beats; pulses 3 then 1 clock apart
        drive(1, 1, 0, ivec(1, 1, 1), 25'h0155555, dvec(0, 0, 0));
        expect_emit(dvec(1, 1, 1), 25'h0155555, 7'h00, 1, 1'b0);
        drive(1, 0, 0, ivec(2, 2, 2), 25'h1AAAAAA, dvec(5, 5, 5));
        drive(1, 0, 0, ivec(3, 3, 3), 25'h0, dvec(0, 0, 0));
        drive(1, 1, 0, ivec(4, 4, 4), 25'h0, dvec(0, 0, 0));
        expect_emit(dvec(14, 14, 14), 25'h1AAAAAA, 7'h00, 3, 1'b0);
        drive(1, 1, 0, ivec(-4, -4, -4), 25'h0155555, dvec(-3, -3, -3));
        expect_emit(dvec(-7, -7, -7), 25'h0155555, 7'h00, 1, 1'b0);
        // flush right after a close must not cancel the pending pulse
        drive(0, 0, 1, '0, '0, '0);
        idle(1);

        // T4: flush in IDLE, then flush with a valid last beat, then 1-beat window
        drive(0, 0, 1, '0, '0, '0);
        drive(1, 0, 0, ivec(50, 50, 50), 25'h44, dvec(1000, 1000, 1000));
        drive(1, 1, 1, ivec(50, 50, 50), 25'h44, dvec(1000, 1000, 1000));
        drive(1, 1, 0, ivec(7, 7, 7), 25'h77, dvec(0, 0, 0));
        expect_emit(dvec(7, 7, 7), 25'h77, 7'h00, 1, 1'b0);
        idle(2);

        // T5: beat limit 7 closes the window with s_err, next beat opens fresh
        for (int k = 0; k < 7; k++)
            drive(1, 0, 0, ivec(1, 1, 1), (k == 0) ? 25'h5 : 25'h1F, dvec(10, 10, 10));
        expect_emit(dvec(17, 17, 17), 25'h5, 7'h00, 7, 1'b1);
        drive(1, 1, 0, ivec(3, 3, 3), 25'h6, dvec(0, 0, 0));
        expect_emit(dvec(3, 3, 3), 25'h6, 7'h00, 1, 1'b0);
        idle(3);
        chk("hold_s_data", bus.s_data, dvec(3, 3, 3));
        chk("hold_s_beats", TW'(bus.s_beats), TW'(1));

        // T6: reset on beat 3 of a 5-beat window, then a fresh window
        drive(1, 0, 0, ivec(1, 1, 1), 25'h9, dvec(20, 20, 20));
        drive(1, 0, 0, ivec(1, 1, 1), 25'h9, dvec(20, 20, 20));
        drive(1, 0, 0, ivec(1, 1, 1), 25'h9, dvec(20, 20, 20));
        rst = 1'b1;
        idle(1);
        chk_zero("midrst");
        rst = 1'b0;
        drive(1, 1, 0, ivec(9, 9, 9), 25'hA, dvec(0, 0, 0));
        expect_emit(dvec(9, 9, 9), 25'hA, 7'h00, 1, 1'b0);
        idle(4);

        chk("pending_expectations", TW'(q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
